fpu_vec_lane_scatter: RTL and testbench
=======================================

# fpu_vec_lane_scatter

Lane scatter/pack unit for the FPU vector path. It accepts a stream of 32-bit scalar lane results from the serialized SIMD FPU. Each beat is written into one of four lanes of a 128-bit vector accumulator, chosen by the same shuffle or default lane index pair the FPU uses for lane selection on its read side. It emits the assembled vector to writeback through a valid/ready handshake; it is the write-side counterpart of the 4:1 lane gather.

## Interface

- LANE_W, default 32, width of one lane; the vector width is 4*LANE_W.
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- inValid  in  1  input beat valid.
- inReady  out  1  unit accepts a beat this cycle.
- inData  in  LANE_W  lane value.
- inIdxShuf  in  2  shuffled destination lane.
- inIdxDfl  in  2  default destination lane.
- inDoShuf  in  1  selects inIdxShuf (1) or inIdxDfl (0).
- inLast  in  1  close the vector after this beat, even if some lanes are unwritten.
- inFlush  in  1  synchronous abort of the accumulation and of any pending output.
- outValid  out  1  assembled vector available.
- outReady  in  1  downstream accepts the vector.
- outData  out  4*LANE_W  vector; lane k is at bits [k*LANE_W +: LANE_W].
- outMask  out  4  lanes actually written in this vector.
- dupErr  out  1  one-cycle pulse: an accepted beat hit a lane already written in the current vector.

## Operation

- Destination lane: dst = inDoShuf ? inIdxShuf : inIdxDfl.
- A beat is accepted when inValid && inReady.
- States:
  - EMPTY: no lanes written.
  - FILL: 1 to 3 lanes written.
  - FULL: vector held on the output; outValid=1.
- Accepted beat in EMPTY (or a restart, see below): clear all lanes to 0, write lane dst, set mask to onehot(dst).
- Accepted beat in FILL: write lane dst and OR onehot(dst) into the mask.
- Duplicate lane: if mask[dst] is already set, the lane is overwritten with the new value, the mask is unchanged, and dupErr pulses the next cycle.
- Vector completion: the vector completes when the post-beat mask equals 4'b1111, or when the accepted beat has inLast=1. The state then goes to FULL; outData is the lane register and outMask is the mask.
- Unwritten lanes in a closed vector read as 0.
- Transitions:
  - EMPTY -> FILL on an accepted beat that does not complete the vector.
  - EMPTY/FILL -> FULL on a completing beat.
  - FILL stays FILL on a non-completing beat.
  - FULL -> EMPTY on outReady with no accepted beat.
  - FULL with outReady and an accepted beat: restart, behaving as an accepted beat from EMPTY; the state becomes FILL or FULL according to that beat.
- inReady = !inFlush && (state != FULL || outReady).
- inFlush: highest priority. Next state EMPTY; lanes, mask and outValid are cleared; any beat offered that cycle is not accepted; dupErr is not raised.
- reset mid-operation: everything returns to reset values immediately; a partially assembled or pending vector is lost.

## Timing

- Reset values: outValid=0, outData=0, outMask=0, dupErr=0, state EMPTY.
- inReady is combinational from state, outReady and inFlush. All other outputs are registered.
- Latency: a completing beat accepted at edge N gives outValid=1 with data from edge N. No combinational path from inData to outData.
- Throughput: one beat per cycle. A 4-lane vector takes 4 input cycles with no bubble between vectors while outReady=1.
- outData and outMask stay stable while outValid && !outReady.
- dupErr is high for exactly the cycle after the offending acceptance.

## Structure

- A shared package, fpu_vec_pkg, holds:
  - the lane count constant (4) and the 2-bit lane index type;
  - the state enum {EMPTY, FILL, FULL};
  - a function returning the lane one-hot.
- Sub-module fpu_vec_lane_dec: combinational destination select (shuffle vs default) plus 2->4 one-hot decode. It is instantiated once.
- The top level holds the state register, the 4-lane data register, the mask register and the handshake logic.

## Test plan

- Fill: beats 0x11111111..0x44444444 with inDoShuf=0, inIdxDfl=0,1,2,3, outReady=1 -> outValid one cycle after the 4th beat; outData=0x44444444_33333333_22222222_11111111; outMask=4'b1111.
- Shuffle and early close: beats 0xA0000000 with inDoShuf=1, inIdxShuf=3, then 0xB0000000 with inIdxShuf=1 and inLast=1 -> outData=0xA0000000_00000000_B0000000_00000000; outMask=4'b1010.
- Duplicate lane: lane 2 written with 0x5, then lane 2 again with 0x6, then lanes 0,1,3 -> dupErr pulses once; lane 2 of the output is 0x6; outMask=4'b1111.
- Backpressure and restart:
  - Hold outReady=0 after FULL -> inReady=0 and outData is stable for 5 cycles.
  - Raise outReady together with inValid (lane 0 = 0x7) -> the old vector is consumed and the next vector starts with mask 4'b0001, other lanes 0.
- Flush: assert inFlush after 2 beats, and separately while FULL -> outValid=0, outMask=0; the next 4 beats produce a clean vector with no residue.
- Async reset: assert reset between clock edges while in FILL -> all outputs 0 before the next edge; outValid=0.

Source files
------------

// File: rtl/fpu_vec_pkg.sv
// Shared types for the FPU vector lane path: lane count, lane index,
// scatter state and the lane one-hot helper.
package fpu_vec_pkg;

    localparam int unsigned LANES = 4;

    typedef logic [1:0] lane_idx_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } state_t;

    function automatic logic [LANES-1:0] lane_onehot(input lane_idx_t idx);
        logic [LANES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fpu_vec_lane_dec.sv
// Destination lane select (shuffle vs default index) and 2->4 one-hot decode.
module fpu_vec_lane_dec
    import fpu_vec_pkg::*;
(
    input  lane_idx_t        i_idx_shuf,
    input  lane_idx_t        i_idx_dfl,
    input  logic             i_do_shuf,
    output lane_idx_t        o_dst,
    output logic [LANES-1:0] o_onehot
);

    lane_idx_t w_dst;

    assign w_dst    = i_do_shuf ? i_idx_shuf : i_idx_dfl;
    assign o_dst    = w_dst;
    assign o_onehot = lane_onehot(w_dst);

endmodule

// File: rtl/fpu_vec_lane_scatter.sv
// Packs a stream of scalar lane results into a 4-lane vector and hands the
// assembled vector to writeback over a valid/ready handshake.
module fpu_vec_lane_scatter
    import fpu_vec_pkg::*;
#(
    parameter int unsigned LANE_W = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic [LANE_W-1:0]       inData,
    input  logic [1:0]              inIdxShuf,
    input  logic [1:0]              inIdxDfl,
    input  logic                    inDoShuf,
    input  logic                    inLast,
    input  logic                    inFlush,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [LANES*LANE_W-1:0] outData,
    output logic [LANES-1:0]        outMask,
    output logic                    dupErr
);

    state_t                  r_state;
    logic [LANES*LANE_W-1:0] r_data;
    logic [LANES-1:0]        r_mask;
    logic                    r_dup;

    lane_idx_t               w_dst;
    logic [LANES-1:0]        w_onehot;
    logic                    w_accept;
    logic                    w_restart;
    logic [LANES-1:0]        w_base_mask;
    logic [LANES-1:0]        w_mask_d;
    logic [LANES*LANE_W-1:0] w_data_d;
    logic                    w_dup;
    logic                    w_complete;

    fpu_vec_lane_dec u_dec (
        .i_idx_shuf (inIdxShuf),
        .i_idx_dfl  (inIdxDfl),
        .i_do_shuf  (inDoShuf),
        .o_dst      (w_dst),
        .o_onehot   (w_onehot)
    );

    assign inReady  = !inFlush && ((r_state != FULL) || outReady);
    assign w_accept = inValid && inReady;

    // Accepting in FULL implies outReady, so the beat opens a fresh vector.
    assign w_restart = (r_state != FILL);

    always_comb begin
        w_base_mask = w_restart ? '0 : r_mask;
        w_mask_d    = w_base_mask | w_onehot;
        w_dup       = |(w_base_mask & w_onehot);
        w_complete  = (w_mask_d == '1) || inLast;
        w_data_d    = '0;
        for (int k = 0; k < LANES; k++) begin
            w_data_d[k*LANE_W +: LANE_W] = w_onehot[k] ? inData :
                (w_restart ? '0 : r_data[k*LANE_W +: LANE_W]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
            r_data  <= '0;
            r_mask  <= '0;
            r_dup   <= 1'b0;
        end else begin
            r_dup <= 1'b0;
            if (inFlush) begin
                r_state <= EMPTY;
                r_data  <= '0;
                r_mask  <= '0;
            end else if (w_accept) begin
                r_data  <= w_data_d;
                r_mask  <= w_mask_d;
                r_state <= w_complete ? FULL : FILL;
                r_dup   <= w_dup;
            end else if ((r_state == FULL) && outReady) begin
                r_state <= EMPTY;
            end
        end
    end

    assign outValid = (r_state == FULL);
    assign outData  = r_data;
    assign outMask  = r_mask;
    assign dupErr   = r_dup;

endmodule

// File: tb/tb_fpu_vec_lane_scatter.sv
// Directed bench for fpu_vec_lane_scatter with hand-computed expectations.
module tb_fpu_vec_lane_scatter;

    logic         clock;
    logic         reset;
    logic         inValid;
    logic         inReady;
    logic [31:0]  inData;
    logic [1:0]   inIdxShuf;
    logic [1:0]   inIdxDfl;
    logic         inDoShuf;
    logic         inLast;
    logic         inFlush;
    logic         outValid;
    logic         outReady;
    logic [127:0] outData;
    logic [3:0]   outMask;
    logic         dupErr;

    int total;
    int bad;

    logic [127:0] held;

    fpu_vec_lane_scatter #(.LANE_W(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .inValid   (inValid),
        .inReady   (inReady),
        .inData    (inData),
        .inIdxShuf (inIdxShuf),
        .inIdxDfl  (inIdxDfl),
        .inDoShuf  (inDoShuf),
        .inLast    (inLast),
        .inFlush   (inFlush),
        .outValid  (outValid),
        .outReady  (outReady),
        .outData   (outData),
        .outMask   (outMask),
        .dupErr    (dupErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one beat on the default index; the shuffle index is set to a
    // different lane so a wrong select shows up.
    task automatic beat(input logic [31:0] d, input logic [1:0] lane, input logic last);
        inValid   = 1'b1;
        inData    = d;
        inIdxDfl  = lane;
        inIdxShuf = ~lane;
        inDoShuf  = 1'b0;
        inLast    = last;
        @(posedge clock);
        #1;
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    task automatic idle();
        inValid = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        inValid   = 1'b0;
        inData    = '0;
        inIdxShuf = '0;
        inIdxDfl  = '0;
        inDoShuf  = 1'b0;
        inLast    = 1'b0;
        inFlush   = 1'b0;
        outReady  = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", {127'd0, outValid}, 128'd0);
        chk("rst_data", outData, 128'd0);
        chk("rst_mask", {124'd0, outMask}, 128'd0);
        chk("rst_dup", {127'd0, dupErr}, 128'd0);
        reset = 1'b0;
        #1;
        chk("rst_inready", {127'd0, inReady}, 128'd1);

        // Full vector through default indices.
        beat(32'h11111111, 2'd0, 1'b0);
        beat(32'h22222222, 2'd1, 1'b0);
        beat(32'h33333333, 2'd2, 1'b0);
        chk("fill_notyet", {127'd0, outValid}, 128'd0);
        chk("fill_mask3", {124'd0, outMask}, 128'h7);
        beat(32'h44444444, 2'd3, 1'b0);
        chk("fill_valid", {127'd0, outValid}, 128'd1);
        chk("fill_data", outData, 128'h44444444_33333333_22222222_11111111);
        chk("fill_mask", {124'd0, outMask}, 128'hF);
        idle();
        chk("fill_consumed", {127'd0, outValid}, 128'd0);

        // Shuffle index select and early close.
        inValid = 1'b1; inData = 32'hA0000000; inDoShuf = 1'b1;
        inIdxShuf = 2'd3; inIdxDfl = 2'd0; inLast = 1'b0;
        @(posedge clock); #1;
        inData = 32'hB0000000; inIdxShuf = 2'd1; inIdxDfl = 2'd2; inLast = 1'b1;
        @(posedge clock); #1;
        inValid = 1'b0; inLast = 1'b0; inDoShuf = 1'b0;
        chk("shuf_valid", {127'd0, outValid}, 128'd1);
        chk("shuf_data", outData, 128'hA0000000_00000000_B0000000_00000000);
        chk("shuf_mask", {124'd0, outMask}, 128'hA);
        idle();

        // Duplicate lane, then held under backpressure.
        outReady = 1'b0;
        beat(32'h5, 2'd2, 1'b0);
        chk("dup_none_first", {127'd0, dupErr}, 128'd0);
        beat(32'h6, 2'd2, 1'b0);
        chk("dup_pulse", {127'd0, dupErr}, 128'd1);
        chk("dup_mask", {124'd0, outMask}, 128'h4);
        beat(32'h10, 2'd0, 1'b0);
        chk("dup_cleared", {127'd0, dupErr}, 128'd0);
        beat(32'h11, 2'd1, 1'b0);
        beat(32'h13, 2'd3, 1'b0);
        chk("dup_valid", {127'd0, outValid}, 128'd1);
        chk("dup_data", outData, 128'h00000013_00000006_00000011_00000010);
        chk("dup_mask_full", {124'd0, outMask}, 128'hF);
        chk("dup_no_repeat", {127'd0, dupErr}, 128'd0);

        held = 128'h00000013_00000006_00000011_00000010;
        inValid = 1'b1; inData = 32'hDEAD; inIdxDfl = 2'd1; inDoShuf = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_inready", {127'd0, inReady}, 128'd0);
            @(posedge clock); #1;
            chk("bp_valid", {127'd0, outValid}, 128'd1);
            chk("bp_data", outData, held);
        end

        // Restart: consume and start a new vector in the same cycle.
        outReady = 1'b1; inData = 32'h7; inIdxDfl = 2'd0;
        #1;
        chk("rs_inready", {127'd0, inReady}, 128'd1);
        @(posedge clock); #1;
        inValid = 1'b0;
        chk("rs_valid", {127'd0, outValid}, 128'd0);
        chk("rs_mask", {124'd0, outMask}, 128'h1);
        chk("rs_data", outData, 128'h7);
        beat(32'h21, 2'd1, 1'b0);
        beat(32'h22, 2'd2, 1'b1);
        chk("rs_close_data", outData, 128'h00000000_00000022_00000021_00000007);
        chk("rs_close_mask", {124'd0, outMask}, 128'h7);
        idle();

        // Flush during fill.
        beat(32'h1, 2'd0, 1'b0);
        beat(32'h2, 2'd1, 1'b0);
        inFlush = 1'b1; inValid = 1'b1; inData = 32'h3; inIdxDfl = 2'd1;
        #1;
        chk("fl_inready", {127'd0, inReady}, 128'd0);
        @(posedge clock); #1;
        inFlush = 1'b0; inValid = 1'b0;
        chk("fl_mask", {124'd0, outMask}, 128'd0);
        chk("fl_data", outData, 128'd0);
        chk("fl_dup", {127'd0, dupErr}, 128'd0);
        outReady = 1'b0;
        beat(32'hC3, 2'd3, 1'b0);
        beat(32'hC2, 2'd2, 1'b0);
        beat(32'hC1, 2'd1, 1'b0);
        beat(32'hC0, 2'd0, 1'b0);
        chk("fl_clean_valid", {127'd0, outValid}, 128'd1);
        chk("fl_clean_data", outData, 128'h000000C3_000000C2_000000C1_000000C0);

        // Flush while FULL.
        inFlush = 1'b1;
        @(posedge clock); #1;
        inFlush = 1'b0;
        chk("flf_valid", {127'd0, outValid}, 128'd0);
        chk("flf_mask", {124'd0, outMask}, 128'd0);
        chk("flf_data", outData, 128'd0);
        outReady = 1'b1;

        // Asynchronous reset while in FILL.
        beat(32'h99, 2'd1, 1'b0);
        chk("ar_pre_mask", {124'd0, outMask}, 128'h2);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_mask", {124'd0, outMask}, 128'd0);
        chk("ar_data", outData, 128'd0);
        chk("ar_valid", {127'd0, outValid}, 128'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        beat(32'h55, 2'd3, 1'b1);
        chk("ar_after_data", outData, 128'h00000055_00000000_00000000_00000000);
        chk("ar_after_mask", {124'd0, outMask}, 128'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
